// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Parents use half_for() to turn a target output frequency into a terminal count.
package clk_div_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  // Half-period terminal count for a square wave at freq Hz from CLK_HZ.
  function automatic int unsigned half_for(input int unsigned freq);
    return CLK_HZ / (2 * freq) - 1;
  endfunction

  localparam int unsigned DEF_HALF_1HZ  = half_for(1);
  localparam int unsigned DEF_HALF_1KHZ = half_for(1000);

  // Where the next cur_half comes from.
  typedef enum logic [1:0] {
    HALF_KEEP,
    HALF_INPUT,
    HALF_SHADOW
  } half_src_e;

endpackage

// File: rtl/clk_divider_prog.sv
// Programmable divider: 50% duty clk_out plus a one-cycle tick on each rising
// edge of clk_out. New half-periods only take effect at period boundaries.
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W    = 28,
  parameter int unsigned DEF_HALF = DEF_HALF_1HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sclr,
  input  logic [CNT_W-1:0] half_in,
  input  logic             load,
  output logic             clk_out,
  output logic             tick,
  output logic             pending,
  output logic [CNT_W-1:0] cur_half
);

  localparam logic [CNT_W-1:0] DEF_HALF_W = CNT_W'(DEF_HALF);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shadow;
  logic             wrap;
  logic             idle_aligned;
  logic             pending_nxt;
  logic             shadow_we;
  half_src_e        half_src;

  assign wrap         = en && !sclr && (cnt == cur_half);
  // With the counter parked at a phase origin a load can be applied at once.
  assign idle_aligned = !en && (cnt == '0) && !clk_out;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    half_src    = HALF_KEEP;
    pending_nxt = pending;
    shadow_we   = 1'b0;
    if (sclr) begin
      pending_nxt = 1'b0;
      if (load)         half_src = HALF_INPUT;
      else if (pending) half_src = HALF_SHADOW;
    end else if (load) begin
      if (wrap || idle_aligned) begin
        half_src    = HALF_INPUT;
        pending_nxt = 1'b0;
      end else begin
        shadow_we   = 1'b1;
        pending_nxt = 1'b1;
      end
    end else if (wrap && pending) begin
      half_src    = HALF_SHADOW;
      pending_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      pending  <= 1'b0;
      // NOTE: the shadow register is reset too; it is only read when pending
      // is set, but a defined value keeps simulation free of X.
      shadow   <= '0;
      cur_half <= DEF_HALF_W;
    end else begin
      if (sclr) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (en) begin
        if (wrap) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= ~clk_out;
        end else begin
          cnt  <= cnt + CNT_W'(1);
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end

      pending <= pending_nxt;
      if (shadow_we) shadow <= half_in;

      case (half_src)
        HALF_INPUT:  cur_half <= half_in;
        HALF_SHADOW: cur_half <= shadow;
        default:     cur_half <= cur_half;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Bench for clk_divider_prog: directed steps from the behaviour rules, then a
// randomized phase, all checked against a position/level reference model.
module tb_clk_divider_prog;

  localparam int W  = 8;
  localparam int DH = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         sclr;
  logic [W-1:0] half_in;
  logic         load;
  logic         clk_out;
  logic         tick;
  logic         pending;
  logic [W-1:0] cur_half;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: position inside the current half-period, output level,
  // half-period in force, and at most one queued value (last load wins).
  int m_pos;
  bit m_lvl;
  bit m_tick;
  int m_half;
  int m_pend_q[$];

  clk_divider_prog #(.CNT_W(W), .DEF_HALF(DH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sclr     (sclr),
    .half_in  (half_in),
    .load     (load),
    .clk_out  (clk_out),
    .tick     (tick),
    .pending  (pending),
    .cur_half (cur_half)
  );

  always #5 clk = ~clk;

  task automatic expect_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [W-1:0] obs, input int exp);
    logic [31:0] o;
    o = 32'(obs);
    vectors++;
    assert (o === 32'(exp)) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_lvl  = 1'b0;
    m_tick = 1'b0;
    m_half = DH;
    m_pend_q.delete();
  endtask

  task automatic model_step(input bit e, input bit s, input bit l, input int h);
    bit boundary;
    bit parked;
    if (s) begin
      m_pos  = 0;
      m_lvl  = 1'b0;
      m_tick = 1'b0;
      if (l)                          m_half = h;
      else if (m_pend_q.size() != 0)  m_half = m_pend_q[0];
      m_pend_q.delete();
      return;
    end
    boundary = e && (m_pos == m_half);
    parked   = !e && (m_pos == 0) && !m_lvl;
    m_tick   = 1'b0;
    if (e) begin
      if (boundary) begin
        m_pos  = 0;
        m_tick = !m_lvl;
        m_lvl  = !m_lvl;
      end else begin
        m_pos++;
      end
    end
    if (l && (boundary || parked)) begin
      m_half = h;
      m_pend_q.delete();
    end else if (l) begin
      m_pend_q.delete();
      m_pend_q.push_back(h);
    end else if (boundary && m_pend_q.size() != 0) begin
      m_half = m_pend_q.pop_front();
    end
  endtask

  task automatic check_model(input string tag);
    expect_bit({tag, "_clk_out"}, clk_out, m_lvl);
    expect_bit({tag, "_tick"}, tick, m_tick);
    expect_bit({tag, "_pending"}, pending, m_pend_q.size() != 0);
    expect_val({tag, "_cur_half"}, cur_half, m_half);
  endtask

  // Apply one cycle of inputs, advance the model with them, check #1 after the edge.
  task automatic run(input bit e, input bit s, input bit l, input int h, input string tag);
    en      = e;
    sclr    = s;
    load    = l;
    half_in = W'(h);
    @(posedge clk);
    model_step(e, s, l, h);
    #1;
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sclr = 1'b0; load = 1'b0; half_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    expect_val("reset_cur_half_def", cur_half, DH);
    expect_bit("reset_clk_out_low", clk_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Free run from reset: rise at cycle 4, fall at 8, tick at 4, 12, 20.
    for (int c = 1; c <= 24; c++) begin
      run(1, 0, 0, 0, "free");
      expect_bit("free_tick_sched", tick, (c % 8) == 4);
      expect_bit("free_clk_sched", clk_out, ((c / 4) % 2) == 1);
    end

    // Mid-period load of 1 at cnt=1: current half completes, then 2-cycle halves.
    run(1, 0, 0, 0, "mid_pre");
    run(1, 0, 1, 1, "mid_load");
    expect_bit("mid_pending_set", pending, 1'b1);
    run(1, 0, 0, 0, "mid_wait");
    expect_val("mid_half_held", cur_half, DH);
    run(1, 0, 0, 0, "mid_wrap");
    expect_val("mid_half_applied", cur_half, 1);
    expect_bit("mid_pending_clr", pending, 1'b0);
    expect_bit("mid_rise_tick", tick, 1'b1);
    run(1, 0, 0, 0, "mid_hi");
    run(1, 0, 0, 0, "mid_fall");
    expect_bit("mid_fall_low", clk_out, 1'b0);

    // Two loads before a boundary: only the last one is applied.
    run(1, 0, 0, 0, "dbl_pre");
    run(0, 0, 1, 5, "dbl_ld5");
    run(0, 0, 1, 2, "dbl_ld2");
    expect_bit("dbl_pending", pending, 1'b1);
    run(1, 0, 0, 0, "dbl_wrap");
    expect_val("dbl_last_wins", cur_half, 2);
    expect_bit("dbl_pending_clr", pending, 1'b0);
    run(1, 0, 0, 0, "dbl_post1");
    run(1, 0, 0, 0, "dbl_post2");
    expect_bit("dbl_pending_stays", pending, 1'b0);

    // Freeze for 5 cycles with clk_out high; the high phase lasts 3+5 cycles.
    for (int c = 0; c < 5; c++) begin
      run(0, 0, 0, 0, "frz");
      expect_bit("frz_hold_hi", clk_out, 1'b1);
      expect_bit("frz_no_tick", tick, 1'b0);
    end
    run(1, 0, 0, 0, "frz_resume");
    expect_bit("frz_fall", clk_out, 1'b0);
    run(1, 0, 0, 0, "frz_lo1");
    run(1, 0, 0, 0, "frz_lo2");
    run(1, 0, 0, 0, "frz_rise");
    expect_bit("frz_rise_tick", tick, 1'b1);

    // sclr with clk_out=1, cnt=2 and a pending value of 3.
    run(1, 0, 0, 0, "sclr_pre");
    run(1, 0, 1, 3, "sclr_load");
    run(1, 1, 0, 0, "sclr");
    expect_bit("sclr_low", clk_out, 1'b0);
    expect_val("sclr_applies", cur_half, 3);
    expect_bit("sclr_pending_clr", pending, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      run(1, 0, 0, 0, "sclr_run");
      expect_bit("sclr_next_rise", clk_out, c == 4);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      run($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 11) == 0, int'($urandom_range(0, 5)), "rand");
    end

    // Asynchronous reset mid-cycle after loading half_in=0.
    run(1, 0, 1, 0, "arst_load");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_model("arst_now");
    expect_val("arst_def_half", cur_half, DH);
    @(posedge clk);
    #1;
    check_model("arst_held");
    @(negedge clk);
    rst = 1'b0;
    run(0, 0, 1, 0, "div2_load");
    expect_val("div2_half0", cur_half, 0);
    expect_bit("div2_no_pending", pending, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      run(1, 0, 0, 0, "div2");
      expect_bit("div2_toggle", clk_out, (c % 2) == 1);
      expect_bit("div2_tick", tick, (c % 2) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
Programmable, parametrised clock divider and tick generator. It is the successor to the fixed 50 MHz -> 1 Hz divider.
- Generates a 50% duty square wave `clk_out` and a one-cycle `tick` strobe from the system clock.
- Half-period is runtime-loadable, with glitch-free application at period boundaries.
- Has an enable and a synchronous phase clear.
- Feeds timers, debouncers and display-scan logic in the lab designs.

Parameters:
CNT_W, 28, width of the internal counter and of `half_in` / `cur_half`.
DEF_HALF, 24999999, terminal count after reset (50 MHz in -> 1 Hz out). Must be < 2**CNT_W.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  count enable; when 0, all state holds.
sclr  in  1  synchronous phase clear.
half_in  in  CNT_W  new terminal count; output period = 2*(half_in+1) enabled cycles.
load  in  1  one-cycle strobe; captures `half_in`.
clk_out  out  1  divided square wave (registered).
tick  out  1  one-cycle pulse, high in the same cycle that `clk_out` rises (registered).
pending  out  1  a loaded value is waiting for the next boundary.
cur_half  out  CNT_W  terminal count currently in use.

Behaviour:
- Reset (async, rst=1): cnt=0, clk_out=0, tick=0, pending=0, shadow=0, cur_half=DEF_HALF.
- Priority each cycle: rst > sclr > load-capture/apply > counting.
- Counting (en=1, sclr=0):
  - If cnt==cur_half: cnt<=0 and clk_out<=~clk_out (a "wrap"). tick<=1 only when clk_out was 0.
  - Otherwise: cnt<=cnt+1, tick<=0.
- en=0: cnt and clk_out hold; tick<=0; load capture still works.
- Load while not in a wrap cycle: shadow<=half_in, pending<=1.
  - Load while pending: shadow is overwritten, last value wins.
- Apply: at the next wrap with pending=1: cur_half<=shadow, pending<=0.
  - The new value governs the half-period starting at cnt=0.
  - The current half-period is never shortened or stretched, so no runt pulses.
- Load in a wrap cycle: cur_half<=half_in directly; pending stays or goes 0. Any older shadow is discarded.
- Load while idle-aligned (en=0, cnt==0, clk_out==0): cur_half<=half_in next cycle; pending=0.
- sclr=1:
  - cnt<=0, clk_out<=0, tick<=0.
  - If pending, cur_half<=shadow and pending<=0.
  - If load is also high, cur_half<=half_in (load wins over shadow).
- half=0 is legal: clk_out toggles every enabled cycle (divide by 2). tick then fires every 2 cycles.
- Counter never exceeds cur_half. No wrap-around hazard, because an applied value always starts from cnt=0.
- Latency: first tick after reset occurs at enabled cycle DEF_HALF+1, counting the first enabled cycle as 1.
- Outputs are registered only: no combinational path from inputs to outputs.

Decomposition:
- Shared package `clk_div_pkg`:
  - constant CLK_HZ = 50_000_000.
  - function `half_for(freq)` = CLK_HZ/(2*freq) - 1, used by parents to compute DEF_HALF and half_in.
  - constants DEF_HALF_1HZ and DEF_HALF_1KHZ.
- The block is a single module; no sub-module is needed.
- Parents needing several rates instantiate several copies.

Test Plan:
- Reset with DEF_HALF=3, en=1 held -> clk_out rises at cycle 4, falls at cycle 8, period 8. tick high exactly at cycles 4, 12, 20.
- Mid-period load of half_in=1 at cnt=1 -> pending=1 until the next wrap. The current half-period completes at 4 cycles, then 2-cycle half-periods follow. cur_half becomes 1 in the wrap cycle.
- Two loads (5 then 2) before a boundary -> only 2 is applied; pending clears once.
- Toggle en=0 for 5 cycles mid-count -> cnt and clk_out frozen, tick stays 0. The count resumes from the frozen value, and the total period is extended by exactly 5.
- Assert sclr with clk_out=1 and cnt=2 -> next cycle clk_out=0 and cnt=0. Next rise is after cur_half+1 enabled cycles. A pending value is applied.
- Assert rst asynchronously mid-cycle with half_in=0 loaded -> outputs go 0 immediately and cur_half=DEF_HALF. After release, a load of half_in=0 makes clk_out toggle every cycle.
